// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch producer for the IF/ID stage buffer.
// Owns the PC, issues one imem request at a time, and presents
// {pc+2, instruction} to the IF/ID buffer together with write-enable and flush.
// It absorbs variable imem latency, hazard stalls and branch redirects.
//
// Optional feature: define FETCH_COUNT_EN to add the fetch_count output, a
// 16-bit wrapping count of cycles with ifid_write=1.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   imem_req     one-cycle fetch request strobe
//   imem_addr    fetch address, valid while imem_req=1
//   imem_valid   one-cycle response strobe, 1..N cycles after imem_req
//   imem_rdata   instruction, valid with imem_valid
//   stall        hazard unit: hold IF/ID contents
//   redirect     taken branch/jump, one-cycle pulse
//   redirect_pc  redirect target (bit 0 ignored)
//   ifid_data    {pc_plus2, instruction} to the IF/ID buffer input
//   ifid_write   IF/ID buffer write enable
//   ifid_flush   IF/ID buffer flush, active-high
//   fetch_count  (FETCH_COUNT_EN only) number of ifid_write cycles, wrapping
module if_fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h0000)
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic                      imem_valid,
    input  logic [INSTR_W-1:0]        imem_rdata,
    input  logic                      stall,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic [ADDR_W+INSTR_W-1:0] ifid_data,
    output logic                      ifid_write,
    output logic                      ifid_flush
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]               fetch_count
`endif
);

    localparam int unsigned DATA_W = ADDR_W + INSTR_W;

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic   [ADDR_W-1:0]   r_pc;
    logic   [INSTR_W-1:0]  r_hold;

    state_t                w_state_nxt;
    logic   [ADDR_W-1:0]   w_pc_nxt;
    logic   [ADDR_W-1:0]   w_pc_plus2;
    logic   [ADDR_W-1:0]   w_redirect_pc;
    logic                  w_hold_load;

    // PC arithmetic wraps naturally at 2^ADDR_W; redirect targets are halfword aligned.
    assign w_pc_plus2    = r_pc + ADDR_W'(2);
    assign w_redirect_pc = {redirect_pc[ADDR_W-1:1], 1'b0};
    assign imem_addr     = r_pc;

    // State, PC and hold register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_hold_load) begin
                r_hold <= imem_rdata;
            end
        end
    end

    // Next-state and outputs. Redirect beats every other event outside BOOT.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_load = 1'b0;
        imem_req    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        ifid_data   = DATA_W'(0);

        case (r_state)
            S_BOOT: begin
                ifid_flush  = 1'b1;
                w_state_nxt = S_REQ;
            end

            S_REQ: begin
                if (redirect) begin
                    // Request is suppressed, so nothing is outstanding.
                    ifid_flush  = 1'b1;
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = S_REQ;
                end else begin
                    imem_req    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    ifid_flush  = 1'b1;
                    w_pc_nxt    = w_redirect_pc;
                    // A coincident response is simply dropped; otherwise drain it later.
                    w_state_nxt = imem_valid ? S_REQ : S_DRAIN;
                end else if (imem_valid) begin
                    if (stall) begin
                        w_hold_load = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        ifid_write  = 1'b1;
                        ifid_data   = {w_pc_plus2, imem_rdata};
                        w_pc_nxt    = w_pc_plus2;
                        w_state_nxt = S_REQ;
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    ifid_flush  = 1'b1;
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    ifid_write  = 1'b1;
                    ifid_data   = {w_pc_plus2, r_hold};
                    w_pc_nxt    = w_pc_plus2;
                    w_state_nxt = S_REQ;
                end
            end

            S_DRAIN: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    w_pc_nxt   = w_redirect_pc;
                end
                // The stale response is discarded whether or not a redirect coincides.
                if (imem_valid) begin
                    w_state_nxt = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

`ifdef FETCH_COUNT_EN
    logic [15:0] r_fetch_count;

    // Count of IF/ID writes; independent of redirect and flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_count <= 16'h0000;
        end else if (ifid_write) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule
